// File: rtl/izh_fixed_pkg.sv
// Signed fixed-point word format and saturating arithmetic shared by the Izhikevich recovery pipeline.
// Every helper returns the clamped value together with a flag that says whether clamping happened.
package izh_fixed_pkg;

  localparam int WORD_W = 20;
  localparam int FRAC_W = 10;

  typedef logic signed [WORD_W-1:0]   word_t;
  typedef logic signed [2*WORD_W-1:0] prod_t;

  typedef struct packed {
    word_t val;
    logic  sat;
  } sat_word_t;

  localparam word_t WORD_MAX  = {1'b0, {(WORD_W-1){1'b1}}};
  localparam word_t WORD_MIN  = {1'b1, {(WORD_W-1){1'b0}}};
  // round(0.02 * 2^Q) and round(0.2 * 2^Q) in integer arithmetic
  localparam word_t A_DEFAULT = word_t'((2 * (2 ** FRAC_W) + 50) / 100);
  localparam word_t B_DEFAULT = word_t'((2 * (2 ** FRAC_W) + 5) / 10);

  function automatic sat_word_t clamp(input prod_t x);
    sat_word_t r;
    if (x > prod_t'(WORD_MAX)) begin
      r.val = WORD_MAX;
      r.sat = 1'b1;
    end else if (x < prod_t'(WORD_MIN)) begin
      r.val = WORD_MIN;
      r.sat = 1'b1;
    end else begin
      r.val = x[WORD_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

  // Full-width product, floor shift by the fractional bits, then clamp.
  function automatic sat_word_t sat_mul(input word_t x, input word_t y);
    prod_t p;
    p = prod_t'(x) * prod_t'(y);
    return clamp(p >>> FRAC_W);
  endfunction

  function automatic sat_word_t sat_add(input word_t x, input word_t y);
    return clamp(prod_t'(x) + prod_t'(y));
  endfunction

  function automatic sat_word_t sat_sub(input word_t x, input word_t y);
    return clamp(prod_t'(x) - prod_t'(y));
  endfunction

endpackage

// File: rtl/izh_param_rf.sv
// Per-channel a/b parameter store: one synchronous write port, one combinational read port.
// A write lands on the clock edge, so a same-cycle read still returns the old pair.
module izh_param_rf
  import izh_fixed_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [CW-1:0] i_wr_ch,
  input  word_t         i_wr_a,
  input  word_t         i_wr_b,
  input  logic [CW-1:0] i_rd_ch,
  output word_t         o_rd_a,
  output word_t         o_rd_b
);

  word_t       r_a [CHANNELS];
  word_t       r_b [CHANNELS];
  logic [CW-1:0] w_wr_idx;
  logic [CW-1:0] w_rd_idx;

  // Out-of-range tags wrap onto the populated channels.
  if ((1 << CW) == CHANNELS) begin : g_pow2
    assign w_wr_idx = i_wr_ch;
    assign w_rd_idx = i_rd_ch;
  end else begin : g_wrap
    assign w_wr_idx = i_wr_ch % CW'(CHANNELS);
    assign w_rd_idx = i_rd_ch % CW'(CHANNELS);
  end

  always_ff @(posedge clk) begin
    // NOTE: this array is reset on purpose: the a/b defaults are part of the neuron model, not don't-cares.
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_a[i] <= A_DEFAULT;
        r_b[i] <= B_DEFAULT;
      end
    end else if (i_we) begin
      r_a[w_wr_idx] <= i_wr_a;
      r_b[w_wr_idx] <= i_wr_b;
    end
  end

  assign o_rd_a = r_a[w_rd_idx];
  assign o_rd_b = r_b[w_rd_idx];

endmodule

// File: rtl/izh_recovery_pipe.sv
// Four-stage evaluator of dw = a*(b*v - w)*step (optionally w + dw) for a time-multiplexed Izhikevich core.
// A stalled output freezes every stage at once; in_ready is simply the inverse of that stall.
module izh_recovery_pipe
  import izh_fixed_pkg::*;
#(
  parameter int  N        = WORD_W,
  parameter int  Q        = FRAC_W,
  parameter int  CHANNELS = 8,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic signed [N-1:0] cfg_a,
  input  logic signed [N-1:0] cfg_b,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_ch,
  input  logic signed [N-1:0] in_v,
  input  logic signed [N-1:0] in_w,
  input  logic signed [N-1:0] in_step,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_ch,
  output logic signed [N-1:0] out_data,
  output logic                out_sat,
  output logic                sat_sticky,
  input  logic                clr_sat
);

  // The saturating helpers are bound to the package word format.
  if (N != WORD_W || Q != FRAC_W) begin : g_fmt_check
    $error("izh_recovery_pipe: N and Q must match izh_fixed_pkg");
  end

  typedef struct packed {
    word_t         p1;
    word_t         a;
    word_t         w;
    word_t         step;
    logic          mode;
    logic [CW-1:0] ch;
    logic          sat;
  } s1_t;

  typedef struct packed {
    word_t         p2;
    word_t         w;
    word_t         step;
    logic          mode;
    logic [CW-1:0] ch;
    logic          sat;
  } s2_t;

  typedef struct packed {
    word_t         p3;
    word_t         w;
    logic          mode;
    logic [CW-1:0] ch;
    logic          sat;
  } s3_t;

  logic      w_stall;
  logic      w_adv;
  logic      w_accept;
  word_t     w_a;
  word_t     w_b;
  sat_word_t w_p1;
  sat_word_t w_d;
  sat_word_t w_p2;
  sat_word_t w_p3;
  sat_word_t w_sum;
  word_t     w_out_data;
  logic      w_out_sat;
  logic [3:1] r_vld;
  s1_t       r_s1;
  s2_t       r_s2;
  s3_t       r_s3;

  assign w_stall  = out_valid & ~out_ready;
  assign w_adv    = ~w_stall;
  assign in_ready = w_adv;
  assign w_accept = in_valid & w_adv;

  izh_param_rf #(
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_param_rf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (cfg_we),
    .i_wr_ch (cfg_ch),
    .i_wr_a  (cfg_a),
    .i_wr_b  (cfg_b),
    .i_rd_ch (in_ch),
    .o_rd_a  (w_a),
    .o_rd_b  (w_b)
  );

  assign w_p1       = sat_mul(w_b, in_v);
  assign w_d        = sat_sub(r_s1.p1, r_s1.w);
  assign w_p2       = sat_mul(r_s1.a, w_d.val);
  assign w_p3       = sat_mul(r_s2.p2, r_s2.step);
  assign w_sum      = sat_add(r_s3.w, r_s3.p3);
  assign w_out_data = r_s3.mode ? w_sum.val : r_s3.p3;
  assign w_out_sat  = r_s3.sat | (r_s3.mode & w_sum.sat);

  always_ff @(posedge clk) begin
    // NOTE: payload registers have no reset; r_vld qualifies them, so their power-up contents are never observed.
    if (w_adv) begin
      r_s1 <= '{p1: w_p1.val, a: w_a, w: in_w, step: in_step, mode: in_mode, ch: in_ch, sat: w_p1.sat};
      r_s2 <= '{p2: w_p2.val, w: r_s1.w, step: r_s1.step, mode: r_s1.mode, ch: r_s1.ch,
                sat: r_s1.sat | w_d.sat | w_p2.sat};
      r_s3 <= '{p3: w_p3.val, w: r_s2.w, mode: r_s2.mode, ch: r_s2.ch, sat: r_s2.sat | w_p3.sat};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_vld     <= {r_vld[2:1], w_accept};
      out_valid <= r_vld[3];
      out_data  <= w_out_data;
      out_ch    <= r_s3.ch;
      out_sat   <= w_out_sat;
    end
  end

  // A saturated result leaving the block wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_sticky <= 1'b0;
    end else if (out_valid & out_ready & out_sat) begin
      sat_sticky <= 1'b1;
    end else if (clr_sat) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_izh_recovery_pipe.sv
// Self-checking bench for izh_recovery_pipe: directed vectors, hand-written corner sequences and random streaming.
// The reference model is a queue of predicted results, each carrying its age in pipeline advances.
module tb_izh_recovery_pipe;

  localparam int     N    = 20;
  localparam int     Q    = 10;
  localparam int     CH   = 8;
  localparam int     CW   = 3;
  localparam longint WMAX = 524287;
  localparam longint WMIN = -524288;

  logic                clk;
  logic                reset;
  logic                cfg_we;
  logic [CW-1:0]       cfg_ch;
  logic signed [N-1:0] cfg_a;
  logic signed [N-1:0] cfg_b;
  logic                in_valid;
  logic                in_ready;
  logic [CW-1:0]       in_ch;
  logic signed [N-1:0] in_v;
  logic signed [N-1:0] in_w;
  logic signed [N-1:0] in_step;
  logic                in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [CW-1:0]       out_ch;
  logic signed [N-1:0] out_data;
  logic                out_sat;
  logic                sat_sticky;
  logic                clr_sat;

  izh_recovery_pipe #(.N(N), .Q(Q), .CHANNELS(CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_v       (in_v),
    .in_w       (in_w),
    .in_step    (in_step),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky),
    .clr_sat    (clr_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int     ch;
    longint data;
    bit     sat;
  } ent_t;

  longint m_a [CH];
  longint m_b [CH];
  ent_t   m_q [$];
  int     m_age [$];
  bit     m_sticky;
  bit     last_accept;
  bit     last_xfer;
  bit     last_stall;

  function automatic longint clampw(input longint x, output bit hit);
    hit = 1'b0;
    if (x > WMAX) begin hit = 1'b1; return WMAX; end
    if (x < WMIN) begin hit = 1'b1; return WMIN; end
    return x;
  endfunction

  function automatic ent_t predict(input int ch, input longint v, input longint w,
                                   input longint st, input bit mode);
    ent_t   r;
    bit     h;
    longint p1, d, p2, p3;
    r.ch  = ch;
    r.sat = 1'b0;
    p1 = clampw((m_b[ch] * v) >>> Q, h);  r.sat |= h;
    d  = clampw(p1 - w, h);               r.sat |= h;
    p2 = clampw((m_a[ch] * d) >>> Q, h);  r.sat |= h;
    p3 = clampw((p2 * st) >>> Q, h);      r.sat |= h;
    if (mode) begin
      r.data = clampw(w + p3, h);
      r.sat |= h;
    end else begin
      r.data = p3;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_a[i] = 20;
      m_b[i] = 205;
    end
    m_q.delete();
    m_age.delete();
    m_sticky = 1'b0;
  endtask

  // One clock: compare at the falling edge, update the model for the coming rising edge.
  task automatic tick();
    ent_t e;
    bit   exp_valid, stall_m, acc, xfer;
    @(negedge clk);
    last_accept = 1'b0;
    last_xfer   = 1'b0;
    last_stall  = 1'b0;
    if (reset) begin
      model_reset();
    end else begin
      exp_valid = (m_q.size() > 0) && (m_age[0] >= 4);
      stall_m   = exp_valid && !out_ready;
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, !stall_m);
      check("sat_sticky", sat_sticky, m_sticky);
      if (exp_valid) begin
        e = m_q[0];
        check("out_data", out_data, e.data);
        check("out_ch", out_ch, e.ch);
        check("out_sat", out_sat, e.sat);
      end
      acc  = in_valid && !stall_m;
      xfer = exp_valid && out_ready;
      if (xfer) begin
        void'(m_q.pop_front());
        void'(m_age.pop_front());
      end
      if (xfer && e.sat) m_sticky = 1'b1;
      else if (clr_sat)  m_sticky = 1'b0;
      if (!stall_m) foreach (m_age[i]) m_age[i]++;
      if (acc) begin
        m_q.push_back(predict(int'(in_ch), longint'(in_v), longint'(in_w), longint'(in_step), in_mode));
        m_age.push_back(1);
      end
      if (cfg_we) begin
        m_a[cfg_ch] = longint'(cfg_a);
        m_b[cfg_ch] = longint'(cfg_b);
      end
      last_accept = acc;
      last_xfer   = xfer;
      last_stall  = stall_m;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int ch;
    int v;
    int w;
    int step;
    bit mode;
    int exp_data;
    bit exp_sat;
  } vec_t;

  task automatic send_vec(input vec_t t, input bit clr_on_xfer, input string tag);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ch     = CW'(t.ch);
    in_v      = N'(t.v);
    in_w      = N'(t.w);
    in_step   = N'(t.step);
    in_mode   = t.mode;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_data"}, out_data, t.exp_data);
    check({tag, "_ch"}, out_ch, t.ch);
    check({tag, "_sat"}, out_sat, t.exp_sat);
    clr_sat = clr_on_xfer;
    tick();
    clr_sat = 1'b0;
  endtask

  function automatic int rnd_word();
    int k;
    k = int'($urandom_range(0, 9));
    if (k < 2) return int'($urandom_range(0, 1048575)) - 524288;
    if (k < 3) begin
      case ($urandom_range(0, 3))
        0:       return 524287;
        1:       return -524288;
        2:       return 0;
        default: return -1;
      endcase
    end
    return int'($urandom_range(0, 16384)) - 8192;
  endfunction

  vec_t vecs [8];

  initial begin
    int sent, got, stalls;

    vecs[0] = '{ch: 0, v: -66560,  w: -13312,  step: 102,     mode: 1, exp_data: -13313,  exp_sat: 0};
    vecs[1] = '{ch: 0, v: -66560,  w: -13312,  step: 102,     mode: 0, exp_data: -1,      exp_sat: 0};
    vecs[2] = '{ch: 1, v: 10240,   w: 0,       step: 1024,    mode: 0, exp_data: 40,      exp_sat: 0};
    vecs[3] = '{ch: 1, v: 10240,   w: 1024,    step: 1024,    mode: 1, exp_data: 1044,    exp_sat: 0};
    vecs[4] = '{ch: 5, v: -524288, w: -524288, step: 1024,    mode: 1, exp_data: -516098, exp_sat: 0};
    vecs[5] = '{ch: 7, v: 10240,   w: 0,       step: -1024,   mode: 0, exp_data: -40,     exp_sat: 0};
    vecs[6] = '{ch: 4, v: 524287,  w: 0,       step: 524287,  mode: 0, exp_data: 524287,  exp_sat: 1};
    vecs[7] = '{ch: 4, v: 524287,  w: 0,       step: -524288, mode: 1, exp_data: -524288, exp_sat: 1};

    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_a = '0; cfg_b = '0;
    in_valid = 1'b0; in_ch = '0; in_v = '0; in_w = '0; in_step = '0; in_mode = 1'b0;
    out_ready = 1'b1; clr_sat = 1'b0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_sat_sticky", sat_sticky, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) send_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Saturating subtract on a reconfigured channel, then sticky set / clear / set-beats-clear.
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
    check("sticky_precleared", sat_sticky, 0);
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_a = N'(1024); cfg_b = N'(1024);
    tick();
    cfg_we = 1'b0;
    send_vec('{ch: 3, v: 523264, w: -523264, step: 1024, mode: 1, exp_data: 1023, exp_sat: 1}, 1'b0, "sat");
    check("sticky_after_sat", sat_sticky, 1);
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;
    check("sticky_cleared", sat_sticky, 0);
    send_vec('{ch: 3, v: 523264, w: -523264, step: 1024, mode: 1, exp_data: 1023, exp_sat: 1}, 1'b1, "sat_vs_clr");
    check("sticky_set_wins", sat_sticky, 1);
    clr_sat = 1'b1; tick(); clr_sat = 1'b0;

    // Config write racing a request on the same channel.
    cfg_we = 1'b1; cfg_ch = 3'd2; cfg_a = N'(0); cfg_b = N'(205);
    send_vec('{ch: 2, v: 10240, w: 0, step: 1024, mode: 0, exp_data: 40, exp_sat: 0}, 1'b0, "race_old_a");
    send_vec('{ch: 2, v: 10240, w: 0, step: 1024, mode: 0, exp_data: 0,  exp_sat: 0}, 1'b0, "race_new_a");

    // Back-pressure: eight back-to-back requests, consumer not ready in cycles 3..6.
    sent = 0; got = 0; stalls = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      in_ch     = CW'(sent);
      in_v      = N'(int'($urandom_range(0, 16384)) - 8192);
      in_w      = N'(int'($urandom_range(0, 16384)) - 8192);
      in_step   = N'($urandom_range(0, 2048));
      in_mode   = 1'($urandom_range(0, 1));
      tick();
      if (last_accept) sent++;
      if (last_xfer) got++;
      if (last_stall) stalls++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent", sent, 8);
    check("bp_received", got, 8);
    check("bp_stall_cycles", stalls, 3);
    check("bp_leftover", m_q.size(), 0);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ch = CW'(i + 1);
      in_v = N'(10240); in_w = N'(0); in_step = N'(1024); in_mode = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("inflight_rst_out_valid", out_valid, 0);
    repeat (8) tick();
    send_vec('{ch: 2, v: 10240, w: 0, step: 1024, mode: 0, exp_data: 40, exp_sat: 0}, 1'b0, "rst_default_ch2");
    send_vec('{ch: 3, v: 10240, w: 0, step: 1024, mode: 0, exp_data: 40, exp_sat: 0}, 1'b0, "rst_default_ch3");

    // Random streaming with random back-pressure and config traffic.
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_ch     = CW'($urandom_range(0, CH - 1));
      in_v      = N'(rnd_word());
      in_w      = N'(rnd_word());
      in_step   = ($urandom_range(0, 3) == 0) ? N'(rnd_word()) : N'($urandom_range(0, 2048));
      in_mode   = 1'($urandom_range(0, 1));
      cfg_we    = ($urandom_range(0, 99) < 8);
      cfg_ch    = CW'($urandom_range(0, CH - 1));
      cfg_a     = ($urandom_range(0, 4) == 0) ? N'(rnd_word()) : N'(int'($urandom_range(0, 4096)) - 2048);
      cfg_b     = ($urandom_range(0, 4) == 0) ? N'(rnd_word()) : N'(int'($urandom_range(0, 4096)) - 2048);
      out_ready = ($urandom_range(0, 99) < 75);
      clr_sat   = ($urandom_range(0, 99) < 5);
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; clr_sat = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && m_q.size() > 0; i++) tick();
    check("random_drained", m_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
